// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush controller.
// Detects load-use hazards between Decode sources and the Execute-stage load
// destination, sequences the post-branch flush window, freezes the pipeline
// while data memory is busy, and latches the halted state after HLT.
// Optional feature macro: HAZARD_STATS_EN adds a saturating 16-bit count of
// cycles spent with the PC held; without it stall_cycles is tied to zero.
// Outputs are Mealy: decoded from the registered state/counter plus the
// current inputs, so they are valid in the same cycle as the stimulus.
module hazard_stall_ctrl #(
   parameter int unsigned BR_FLUSH_CYCLES = 1   // legal 1..3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  id_srcReg1,
   input  logic [3:0]  id_srcReg2,
   input  logic        id_src1_used,
   input  logic        id_src2_used,
   input  logic        id_is_hlt,
   input  logic [3:0]  ex_dstReg,
   input  logic        ex_mem_read,
   input  logic        ex_br_taken,
   input  logic        dmem_busy,
   output logic        pc_stall,
   output logic        fd_stall,
   output logic        de_stall,
   output logic        fd_flush,
   output logic        de_flush,
   output logic        halted,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_BR_FLUSH = 2'd1,
      ST_HALTED   = 2'd2
   } state_t;

   // Counter value loaded on a taken branch: the branch cycle itself is the
   // first flush cycle, the counter covers the remaining ones.
   localparam logic [1:0] FLUSH_RELOAD = 2'(BR_FLUSH_CYCLES - 1);

   state_t     state_q;
   logic [1:0] flush_cnt_q;
   logic       halted_q;
   logic       lu;

   // Register 0 is hard-wired zero, so a load into it can never be a hazard.
   assign lu = ex_mem_read && (ex_dstReg != 4'd0) &&
               ((id_src1_used && (id_srcReg1 == ex_dstReg)) ||
                (id_src2_used && (id_srcReg2 == ex_dstReg)));

   // Decode the per-cycle stall/flush controls in strict priority order.
   always_comb begin
      pc_stall = 1'b0;
      fd_stall = 1'b0;
      de_stall = 1'b0;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      if (rst) begin
         // everything quiet while in reset
      end else if (dmem_busy) begin
         pc_stall = 1'b1;
         fd_stall = 1'b1;
         de_stall = 1'b1;
      end else if (state_q == ST_HALTED) begin
         // hold fetch, let the back end drain with bubbles
         pc_stall = 1'b1;
         fd_stall = 1'b1;
         de_flush = 1'b1;
      end else if (ex_br_taken || (state_q == ST_BR_FLUSH)) begin
         fd_flush = 1'b1;
         de_flush = 1'b1;
      end else if (lu) begin
         // load advances, one bubble enters Execute
         pc_stall = 1'b1;
         fd_stall = 1'b1;
         de_flush = 1'b1;
      end else if (id_is_hlt) begin
         pc_stall = 1'b1;
         fd_flush = 1'b1;
      end
   end

   assign halted = halted_q && !rst;

   // Advance state, flush counter and halted flag; dmem_busy freezes all of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 2'd0;
         halted_q    <= 1'b0;
      end else if (!dmem_busy) begin
         case (state_q)
            ST_HALTED: begin
               state_q  <= ST_HALTED;
               halted_q <= 1'b1;
            end
            ST_RUN, ST_BR_FLUSH: begin
               if (ex_br_taken) begin
                  // a same-cycle HLT is wrong-path and simply dropped here
                  if (BR_FLUSH_CYCLES > 1) begin
                     state_q     <= ST_BR_FLUSH;
                     flush_cnt_q <= FLUSH_RELOAD;
                  end else begin
                     state_q     <= ST_RUN;
                     flush_cnt_q <= 2'd0;
                  end
               end else if (state_q == ST_BR_FLUSH) begin
                  if (flush_cnt_q <= 2'd1) begin
                     state_q     <= ST_RUN;
                     flush_cnt_q <= 2'd0;
                  end else begin
                     flush_cnt_q <= flush_cnt_q - 2'd1;
                  end
               end else if (!lu && id_is_hlt) begin
                  state_q  <= ST_HALTED;
                  halted_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_RUN;
               flush_cnt_q <= 2'd0;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stat_q;

   // Count cycles with the PC held, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= 16'h0000;
      end else if (pc_stall && (stat_q != 16'hFFFF)) begin
         stat_q <= stat_q + 16'h0001;
      end
   end

   assign stall_cycles = rst ? 16'h0000 : stat_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl, instantiated with BR_FLUSH_CYCLES=3.
// Each step drives one cycle of inputs just after a rising edge, checks the
// Mealy outputs on the falling edge, then lets the rising edge advance state.
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  id_srcReg1, id_srcReg2, ex_dstReg;
   logic        id_src1_used, id_src2_used, id_is_hlt;
   logic        ex_mem_read, ex_br_taken, dmem_busy;
   logic        pc_stall, fd_stall, de_stall, fd_flush, de_flush, halted;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   hazard_stall_ctrl #(.BR_FLUSH_CYCLES(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_srcReg1   (id_srcReg1),
      .id_srcReg2   (id_srcReg2),
      .id_src1_used (id_src1_used),
      .id_src2_used (id_src2_used),
      .id_is_hlt    (id_is_hlt),
      .ex_dstReg    (ex_dstReg),
      .ex_mem_read  (ex_mem_read),
      .ex_br_taken  (ex_br_taken),
      .dmem_busy    (dmem_busy),
      .pc_stall     (pc_stall),
      .fd_stall     (fd_stall),
      .de_stall     (de_stall),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   // Expected output bundle: {pc_stall, fd_stall, de_stall, fd_flush, de_flush, halted}
   localparam logic [5:0] E_IDLE = 6'b000000;
   localparam logic [5:0] E_LU   = 6'b110010;
   localparam logic [5:0] E_BUSY = 6'b111000;
   localparam logic [5:0] E_FL   = 6'b000110;
   localparam logic [5:0] E_HLT  = 6'b100100;
   localparam logic [5:0] E_HALT = 6'b110011;
   localparam logic [5:0] E_HBSY = 6'b111001;

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] s1, s2, dst;
      logic       u1, u2, hlt, mr, br, busy;
      logic [5:0] exp;
   } vec_t;

   vec_t vq[$];

   // ---------------- driver ----------------
   task automatic add(input string name, input logic r,
                      input logic [3:0] s1, input logic u1,
                      input logic [3:0] s2, input logic u2,
                      input logic [3:0] dst, input logic mr,
                      input logic br, input logic hlt, input logic busy,
                      input logic [5:0] exp);
      vec_t v;
      v.name = name; v.rst = r; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
      v.dst = dst; v.mr = mr; v.br = br; v.hlt = hlt; v.busy = busy; v.exp = exp;
      vq.push_back(v);
   endtask

   // ---------------- scoreboard ----------------
   task automatic step(input vec_t v);
      logic [5:0] act;
      rst = v.rst; id_srcReg1 = v.s1; id_src1_used = v.u1;
      id_srcReg2 = v.s2; id_src2_used = v.u2; ex_dstReg = v.dst;
      ex_mem_read = v.mr; ex_br_taken = v.br; id_is_hlt = v.hlt;
      dmem_busy = v.busy;
      @(negedge clk);
      act = {pc_stall, fd_stall, de_stall, fd_flush, de_flush, halted};
      n_checks++;
      if (act !== v.exp) begin
         n_fail++;
         $display("FAIL %s: got pc/fd/de_stall,fd/de_flush,halted=%b expected %b",
                  v.name, act, v.exp);
      end
`ifndef HAZARD_STATS_EN
      n_checks++;
      if (stall_cycles !== 16'h0000) begin
         n_fail++;
         $display("FAIL %s_stats_tied: got stall_cycles=%h expected 0000",
                  v.name, stall_cycles);
      end
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic run_queue();
      while (vq.size() > 0) step(vq.pop_front());
   endtask

`ifdef HAZARD_STATS_EN
   task automatic check_stats(input string name, input logic [15:0] exp);
      @(negedge clk);
      n_checks++;
      if (stall_cycles !== exp) begin
         n_fail++;
         $display("FAIL %s: got stall_cycles=%h expected %h", name, stall_cycles, exp);
      end
   endtask
`endif

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; id_srcReg1 = 4'd0; id_srcReg2 = 4'd0; ex_dstReg = 4'd0;
      id_src1_used = 1'b0; id_src2_used = 1'b0; id_is_hlt = 1'b0;
      ex_mem_read = 1'b0; ex_br_taken = 1'b0; dmem_busy = 1'b0;
      @(posedge clk);
      #1;

      //   name          rst s1  u1 s2  u2 dst mr br hl bz exp
      add("reset",       1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      add("rst_gate",    1, 3,  1, 0,  0, 3,  1, 1, 1, 1, E_IDLE);
      add("idle",        0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      add("lu_src1",     0, 3,  1, 0,  0, 3,  1, 0, 0, 0, E_LU);
      add("lu_clear",    0, 3,  1, 0,  0, 3,  0, 0, 0, 0, E_IDLE);
      add("lu_src2",     0, 1,  1, 5,  1, 5,  1, 0, 0, 0, E_LU);
      add("lu_reg0",     0, 0,  1, 0,  1, 0,  1, 0, 0, 0, E_IDLE);
      add("lu_unused",   0, 3,  0, 3,  0, 3,  1, 0, 0, 0, E_IDLE);
      add("lu_no_match", 0, 2,  1, 4,  1, 3,  1, 0, 0, 0, E_IDLE);
      add("busy",        0, 0,  0, 0,  0, 0,  0, 0, 0, 1, E_BUSY);
      add("br_lu_hlt",   0, 3,  1, 0,  0, 3,  1, 1, 1, 0, E_FL);
      add("br_flush2",   0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("br_flush3",   0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("br_done",     0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      add("hlt",         0, 0,  0, 0,  0, 0,  0, 0, 1, 0, E_HLT);
      add("halted",      0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_HALT);
      add("halt_sticky", 0, 3,  1, 0,  0, 3,  1, 1, 0, 0, E_HALT);
      add("halt_busy",   0, 0,  0, 0,  0, 0,  0, 0, 0, 1, E_HBSY);
      add("halt_after",  0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_HALT);
      add("halt_rst",    1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      add("post_rst",    0, 0,  0, 0,  0, 0,  0, 0, 1, 0, E_HLT);
      add("post_rst_h",  1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      run_queue();

      // branch with a memory freeze in its second cycle: window stretches to 4 clocks
      add("frz_br",      0, 0,  0, 0,  0, 0,  0, 1, 0, 0, E_FL);
      add("frz_busy",    0, 0,  0, 0,  0, 0,  0, 0, 0, 1, E_BUSY);
      add("frz_fl2",     0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("frz_fl3",     0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("frz_done",    0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      // a branch presented under dmem_busy is ignored
      add("busy_br",     0, 0,  0, 0,  0, 0,  0, 1, 0, 1, E_BUSY);
      add("busy_br_ign", 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      // second branch inside the window reloads the counter
      add("rl_br1",      0, 0,  0, 0,  0, 0,  0, 1, 0, 0, E_FL);
      add("rl_fl",       0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("rl_br2",      0, 0,  0, 0,  0, 0,  0, 1, 0, 0, E_FL);
      add("rl_fl2",      0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("rl_fl3",      0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_FL);
      add("rl_done",     0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      // reset in the middle of a flush window leaves no residual flush
      add("rb_br",       0, 0,  0, 0,  0, 0,  0, 1, 0, 0, E_FL);
      add("rb_rst",      1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      add("rb_after",    0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      // load-use outranks HLT, and the HLT is not taken that cycle
      add("lu_hlt",      0, 7,  1, 0,  0, 7,  1, 0, 1, 0, E_LU);
      add("lu_hlt_nxt",  0, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      run_queue();

`ifdef HAZARD_STATS_EN
      add("st_rst",      1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      run_queue();
      for (int i = 0; i < 5; i++)
         add("st_lu",    0, 3,  1, 0,  0, 3,  1, 0, 0, 0, E_LU);
      run_queue();
      check_stats("stats_five", 16'd5);
      @(posedge clk);
      #1;
      force dut.stat_q = 16'hFFFE;
      #1;
      release dut.stat_q;
      add("st_sat1",     0, 3,  1, 0,  0, 3,  1, 0, 0, 0, E_LU);
      add("st_sat2",     0, 3,  1, 0,  0, 3,  1, 0, 0, 0, E_LU);
      add("st_sat3",     0, 3,  1, 0,  0, 3,  1, 0, 0, 0, E_LU);
      run_queue();
      check_stats("stats_saturate", 16'hFFFF);
      @(posedge clk);
      #1;
      add("st_clr",      1, 0,  0, 0,  0, 0,  0, 0, 0, 0, E_IDLE);
      run_queue();
      check_stats("stats_clear", 16'h0000);
`endif

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller that produces the stall and flush controls consumed by the PC register, the Fetch/Decode register and the Decode/Execute register. It compares decode-stage source registers against the in-flight Execute-stage destination to insert load-use bubbles. It also sequences branch-flush windows and data-memory freezes, and latches the halted state. Its outputs drive the `stall_en` pins of the pipeline registers.

## Interface
Parameters:
- BR_FLUSH_CYCLES, 1, cycles of Fetch/Decode flush after a taken branch; legal 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_srcReg1  in  4  decode-stage source register 1
- id_srcReg2  in  4  decode-stage source register 2
- id_src1_used  in  1  decode instruction reads srcReg1
- id_src2_used  in  1  decode instruction reads srcReg2
- id_is_hlt  in  1  decode instruction is HLT
- ex_dstReg  in  4  execute-stage destination register
- ex_mem_read  in  1  execute-stage instruction is a load
- ex_br_taken  in  1  execute stage resolved a taken branch this cycle
- dmem_busy  in  1  data memory not ready; whole pipeline must freeze
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold Fetch/Decode register
- de_stall  out  1  hold Decode/Execute register (to its stall_en)
- fd_flush  out  1  load NOP into Fetch/Decode
- de_flush  out  1  load bubble into Decode/Execute
- halted  out  1  processor halted
- stall_cycles  out  16  stall statistics (only with HAZARD_STATS_EN)

## Operation
- State machine, 2-bit encoding: RUN, BR_FLUSH, HALTED. Reset → RUN. Flush counter reset → 0.
- Load-use hazard (lu): ex_mem_read && ex_dstReg != 0 && ((id_src1_used && id_srcReg1 == ex_dstReg) || (id_src2_used && id_srcReg2 == ex_dstReg)).
- Priority per cycle, highest first:
  1. dmem_busy.
  2. HALTED.
  3. ex_br_taken or BR_FLUSH.
  4. lu.
  5. id_is_hlt.
- dmem_busy=1: pc_stall=fd_stall=de_stall=1; both flushes 0. State, counter and pending events are frozen. ex_br_taken is ignored this cycle and must be re-presented.
- HALTED: pc_stall=fd_stall=1; de_stall=0; de_flush=1, so the pipeline drains with bubbles; halted=1. Exit only by rst.
- ex_br_taken=1 in RUN: fd_flush=de_flush=1 this cycle.
  - If BR_FLUSH_CYCLES>1: counter ← BR_FLUSH_CYCLES-1, state ← BR_FLUSH.
- BR_FLUSH: fd_flush=1, de_flush=1; counter decrements each cycle; the cycle counter==1 returns to RUN.
  - A new ex_br_taken in BR_FLUSH reloads the counter.
- lu (RUN, no branch): pc_stall=fd_stall=1, de_flush=1, de_stall=0. The load advances and one bubble enters EX. No state change.
- id_is_hlt (RUN, no lu, no branch): pc_stall=1, fd_flush=1; state ← HALTED next cycle.
  - HLT suppressed by a same-cycle taken branch is wrong-path and is discarded.
- All other cases: all outputs 0.
- Register 0 is never a hazard source.

## Timing
- Outputs are Mealy: combinational from registered state/counter plus current inputs, valid in the same cycle as the stimulus.
- State, counter and halted update on the rising clk edge.
- Reset: state RUN, counter 0. During rst=1 all stall/flush outputs are 0, halted=0 and stall_cycles=0.
- Reset asserted mid-BR_FLUSH or in HALTED: back to RUN on the next edge with no residual flush.
- A load-use costs exactly 1 bubble. A taken branch costs BR_FLUSH_CYCLES flush cycles, excluding dmem_busy freeze cycles.

## Configuration
- HAZARD_STATS_EN defined: stall_cycles is a 16-bit counter that increments on every non-reset cycle with pc_stall=1.
  - It saturates at 16'hFFFF and clears on rst.
- HAZARD_STATS_EN undefined: stall_cycles is tied to 16'h0000 and no counter flops exist.

## Test plan
- Load-use: ex_mem_read=1, ex_dstReg=4'h3, id_srcReg1=4'h3, id_src1_used=1 → same cycle pc_stall=fd_stall=de_flush=1, de_stall=0. Next cycle with ex_mem_read=0 → all 0.
- Zero/unused register: ex_dstReg=0 matching srcReg1=0, or a match with id_src1_used=0 → no stall.
- Branch, BR_FLUSH_CYCLES=3: ex_br_taken pulse → fd_flush=de_flush=1 for 3 consecutive cycles, then 0. With dmem_busy=1 in cycle 2 → flush pauses one cycle and the window extends to 4 clocks.
- Branch + lu + id_is_hlt in the same cycle → flush only, no HALTED entry, no pc_stall.
- HLT: id_is_hlt=1 → pc_stall=fd_flush=1; then halted=1 permanently. rst=1 → halted=0 after the edge.
- Stats (HAZARD_STATS_EN): hold lu for 5 cycles → stall_cycles=5. Preload near 16'hFFFF → saturates, no wrap.
